// File: rtl/serpent_bitslice_perm.sv
// Serpent bitslice initial/final permutation with a 2-entry in-order output buffer.
// Each block is permuted on entry and carries its own direction bit through the buffer.
module serpent_bitslice_perm #(
  parameter int NWORDS = 4,
  parameter int WORD_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_mode,
  input  logic [NWORDS*WORD_W-1:0] i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_mode,
  output logic [NWORDS*WORD_W-1:0] o_data,
  output logic [1:0]               o_level
);

  localparam int W = NWORDS * WORD_W;

  // Bit b of slice word w moves to position NWORDS*b + w.
  function automatic logic [W-1:0] perm_ip(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = {W{1'b0}};
    for (int w = 0; w < NWORDS; w++) begin
      for (int b = 0; b < WORD_W; b++) begin
        y[NWORDS*b + w] = x[WORD_W*w + b];
      end
    end
    return y;
  endfunction

  function automatic logic [W-1:0] perm_fp(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = {W{1'b0}};
    for (int w = 0; w < NWORDS; w++) begin
      for (int b = 0; b < WORD_W; b++) begin
        y[WORD_W*w + b] = x[NWORDS*b + w];
      end
    end
    return y;
  endfunction

  logic [1:0]   cnt;
  logic [1:0]   cnt_nxt;
  logic         push;
  logic         pop;
  logic [W-1:0] entry_data;
  logic [W-1:0] head_data_nxt;
  logic         head_mode_nxt;
  logic [W-1:0] tail_data;
  logic [W-1:0] tail_data_nxt;
  logic         tail_mode;
  logic         tail_mode_nxt;

  // Next-state computation for the buffer; o_data/o_mode are the head entry itself.
  always_comb begin
    push          = i_valid & o_ready;
    pop           = o_valid & i_ready;
    entry_data    = i_mode ? perm_fp(i_data) : perm_ip(i_data);
    cnt_nxt       = cnt;
    head_data_nxt = o_data;
    head_mode_nxt = o_mode;
    tail_data_nxt = tail_data;
    tail_mode_nxt = tail_mode;
    if (i_clear) begin
      cnt_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            head_data_nxt = entry_data;
            head_mode_nxt = i_mode;
          end else begin
            tail_data_nxt = entry_data;
            tail_mode_nxt = i_mode;
          end
          cnt_nxt = cnt + 2'd1;
        end
        2'b01: begin
          head_data_nxt = tail_data;
          head_mode_nxt = tail_mode;
          cnt_nxt       = cnt - 2'd1;
        end
        // Push with pop only happens at one entry held: the new block becomes the head.
        2'b11: begin
          head_data_nxt = entry_data;
          head_mode_nxt = i_mode;
          cnt_nxt       = cnt;
        end
        default: begin
          cnt_nxt = cnt;
        end
      endcase
    end
  end

  // Buffer state and registered handshake/status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt       <= 2'd0;
      o_valid   <= 1'b0;
      o_ready   <= 1'b1;
      o_level   <= 2'd0;
      o_mode    <= 1'b0;
      o_data    <= {W{1'b0}};
      tail_mode <= 1'b0;
      tail_data <= {W{1'b0}};
    end else begin
      cnt       <= cnt_nxt;
      o_valid   <= (cnt_nxt != 2'd0);
      o_ready   <= (cnt_nxt != 2'd2);
      o_level   <= cnt_nxt;
      o_mode    <= head_mode_nxt;
      o_data    <= head_data_nxt;
      tail_mode <= tail_mode_nxt;
      tail_data <= tail_data_nxt;
    end
  end

endmodule

// File: tb/tb_serpent_bitslice_perm.sv
// Self-checking bench for serpent_bitslice_perm: scoreboard of permuted blocks,
// directed bit vectors, round trips, backpressure, streaming, clear and reset.
module tb_serpent_bitslice_perm;

  typedef struct packed {
    logic         mode;
    logic [127:0] data;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         valid;
  logic         up_ready;
  logic         mode;
  logic [127:0] data;
  logic         out_valid;
  logic         ds_ready;
  logic         out_mode;
  logic [127:0] out_data;
  logic [1:0]   level;

  logic         s_clear;
  logic         s_valid;
  logic         s_up_ready;
  logic         s_mode;
  logic [15:0]  s_data;
  logic         s_out_valid;
  logic         s_ds_ready;
  logic         s_out_mode;
  logic [15:0]  s_out_data;
  logic [1:0]   s_level;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  serpent_bitslice_perm dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_valid(valid), .o_ready(up_ready),
    .i_mode(mode), .i_data(data), .o_valid(out_valid), .i_ready(ds_ready),
    .o_mode(out_mode), .o_data(out_data), .o_level(level)
  );

  serpent_bitslice_perm #(.NWORDS(2), .WORD_W(8)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_clear(s_clear), .i_valid(s_valid), .o_ready(s_up_ready),
    .i_mode(s_mode), .i_data(s_data), .o_valid(s_out_valid), .i_ready(s_ds_ready),
    .o_mode(s_out_mode), .o_data(s_out_data), .o_level(s_level)
  );

  // Output index j reads input index derived from j (IP: j = 4b+w, FP: j = 32w+b).
  function automatic logic [127:0] ref_perm(input logic m, input logic [127:0] x);
    logic [127:0] y;
    for (int j = 0; j < 128; j++) begin
      if (!m) y[j] = x[32*(j%4) + j/4];
      else    y[j] = x[4*(j%32) + j/32];
    end
    return y;
  endfunction

  function automatic logic [15:0] ref_small_ip(input logic [15:0] x);
    logic [15:0] y;
    for (int j = 0; j < 16; j++) y[j] = x[8*(j%2) + j/2];
    return y;
  endfunction

  // One clock: note the handshakes seen before the edge, record accepted blocks.
  task automatic tick(output bit acc, output bit got, output sb_t seen);
    sb_t e;
    acc = valid && up_ready;
    got = out_valid && ds_ready;
    seen.mode = out_mode;
    seen.data = out_data;
    if (acc && !clear) begin
      e.mode = mode;
      e.data = ref_perm(mode, data);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; valid = 1'b0; ds_ready = 1'b0; mode = 1'b0; data = 128'd0;
    s_clear = 1'b0; s_valid = 1'b0; s_ds_ready = 1'b1; s_mode = 1'b0; s_data = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    total++; if (level !== 2'd0) begin bad++; $display("FAIL reset_level got %0d want 0", level); end
    total++; if (up_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", up_ready); end
    total++; if (out_mode !== 1'b0) begin bad++; $display("FAIL reset_mode got %b want 0", out_mode); end
    total++; if (out_data !== 128'd0) begin bad++; $display("FAIL reset_data got %h want 0", out_data); end
    #2 rst = 1'b0;
  endtask

  task automatic test_bits();
    int ib[5] = '{0, 32, 127, 31, 1};
    int ob[5] = '{0, 1, 127, 124, 32};
    bit md[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [127:0] one = 128'd1;
    bit acc, got;
    sb_t seen, e;
    ds_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; mode = md[i]; data = one << ib[i];
      tick(acc, got, seen);
      valid = 1'b0;
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL bits_accept[%0d] got %b want 1", i, acc); end
      total++; if (out_valid !== 1'b1 || level !== 2'd1) begin
        bad++; $display("FAIL bits_latency[%0d] valid %b level %0d want 1/1", i, out_valid, level);
      end
      total++; if (out_data !== (one << ob[i]) || out_mode !== md[i]) begin
        bad++; $display("FAIL bits_map[%0d] got %h want %h", i, out_data, one << ob[i]);
      end
      tick(acc, got, seen);
      total++;
      if (!got || sb.size() == 0) begin bad++; $display("FAIL bits_pop[%0d] got %b want 1", i, got); end
      else begin
        e = sb.pop_front();
        if (seen !== e) begin bad++; $display("FAIL bits_sb[%0d] got %h want %h", i, seen, e); end
      end
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] x;
    bit acc, got;
    sb_t seen, e;
    ds_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      valid = 1'b1; mode = 1'b0; data = x;
      tick(acc, got, seen);
      mode = 1'b1; data = out_data;
      tick(acc, got, seen);
      total++;
      if (!got || sb.size() == 0) begin bad++; $display("FAIL rt_ip_pop[%0d] got %b", i, got); end
      else begin
        e = sb.pop_front();
        if (seen !== e) begin bad++; $display("FAIL rt_ip[%0d] got %h want %h", i, seen, e); end
      end
      total++; if (out_data !== x || out_mode !== 1'b1) begin
        bad++; $display("FAIL rt_back[%0d] got %h want %h", i, out_data, x);
      end
      valid = 1'b0;
      tick(acc, got, seen);
      total++;
      if (!got || sb.size() == 0) begin bad++; $display("FAIL rt_fp_pop[%0d] got %b", i, got); end
      else begin
        e = sb.pop_front();
        if (seen !== e) begin bad++; $display("FAIL rt_fp[%0d] got %h want %h", i, seen, e); end
      end
    end
  endtask

  task automatic test_small();
    logic [15:0] x;
    s_valid = 1'b1; s_mode = 1'b0; s_data = 16'h0100;
    @(posedge clk); #1;
    total++; if (s_out_data !== 16'h0002) begin bad++; $display("FAIL small_bit8 got %h want 0002", s_out_data); end
    for (int i = 0; i < 200; i++) begin
      x = 16'($urandom);
      s_mode = 1'b0; s_data = x;
      @(posedge clk); #1;
      total++; if (s_out_data !== ref_small_ip(x)) begin
        bad++; $display("FAIL small_ip[%0d] got %h want %h", i, s_out_data, ref_small_ip(x));
      end
      s_mode = 1'b1; s_data = s_out_data;
      @(posedge clk); #1;
      total++; if (s_out_data !== x) begin bad++; $display("FAIL small_rt[%0d] got %h want %h", i, s_out_data, x); end
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] blk[3];
    logic [127:0] ord[3];
    bit acc, got;
    sb_t seen, e;
    int n;
    ds_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      blk[i] = {$urandom, $urandom, $urandom, $urandom};
      ord[i] = ref_perm(i[0], blk[i]);
    end
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mode = i[0]; data = blk[i];
      tick(acc, got, seen);
      total++; if (acc !== (i < 2)) begin bad++; $display("FAIL bp_accept[%0d] got %b want %b", i, acc, i < 2); end
    end
    total++; if (level !== 2'd2 || up_ready !== 1'b0) begin
      bad++; $display("FAIL bp_full level %0d ready %b want 2/0", level, up_ready);
    end
    ds_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      tick(acc, got, seen);
      if (acc) valid = 1'b0;
      if (got) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL bp_underflow at output %0d", n); end
        else begin
          e = sb.pop_front();
          if (seen !== e || seen.data !== ord[n]) begin
            bad++; $display("FAIL bp_order[%0d] got %h want %h", n, seen.data, ord[n]);
          end
        end
        n++;
      end
    end
    valid = 1'b0;
    total++; if (n != 3) begin bad++; $display("FAIL bp_count got %0d want 3", n); end
    tick(acc, got, seen);
    total++; if (out_valid !== 1'b0 || sb.size() != 0) begin
      bad++; $display("FAIL bp_drain valid %b pending %0d want 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_streaming();
    bit acc, got;
    sb_t seen, e;
    int n = 0;
    ds_ready = 1'b1;
    valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      mode = (c % 2 == 1); data = {$urandom, $urandom, $urandom, $urandom};
      tick(acc, got, seen);
      if (got) begin
        total++; n++;
        if (sb.size() == 0) begin bad++; $display("FAIL stream_underflow cycle %0d", c); end
        else begin
          e = sb.pop_front();
          if (seen !== e) begin bad++; $display("FAIL stream_data[%0d] got %h want %h", c, seen, e); end
        end
      end
      total++; if (acc !== 1'b1 || got !== (c > 0) || level !== 2'd1) begin
        bad++; $display("FAIL stream_rate[%0d] acc %b got %b level %0d", c, acc, got, level);
      end
    end
    valid = 1'b0;
    tick(acc, got, seen);
    if (got) begin
      n++;
      e = sb.pop_front();
      total++; if (seen !== e) begin bad++; $display("FAIL stream_last got %h want %h", seen, e); end
    end
    total++; if (n != 16) begin bad++; $display("FAIL stream_count got %0d want 16", n); end
  endtask

  task automatic test_clear();
    bit acc, got;
    sb_t seen, e;
    ds_ready = 1'b0;
    valid = 1'b1; mode = 1'b1;
    repeat (2) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      tick(acc, got, seen);
    end
    total++; if (level !== 2'd2) begin bad++; $display("FAIL clr_fill level %0d want 2", level); end
    clear = 1'b1; data = {$urandom, $urandom, $urandom, $urandom};
    tick(acc, got, seen);
    clear = 1'b0; valid = 1'b0; sb.delete();
    total++; if (level !== 2'd0 || out_valid !== 1'b0 || up_ready !== 1'b1) begin
      bad++; $display("FAIL clr_full level %0d valid %b ready %b want 0/0/1", level, out_valid, up_ready);
    end
    valid = 1'b1;
    tick(acc, got, seen);
    clear = 1'b1;
    tick(acc, got, seen);
    clear = 1'b0; valid = 1'b0; sb.delete();
    total++; if (level !== 2'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL clr_drop level %0d valid %b want 0/0", level, out_valid);
    end
    valid = 1'b1;
    repeat (2) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      tick(acc, got, seen);
    end
    #3 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || level !== 2'd0 || up_ready !== 1'b1 ||
                 out_mode !== 1'b0 || out_data !== 128'd0) begin
      bad++; $display("FAIL rst_async valid %b level %0d ready %b mode %b data %h",
                      out_valid, level, up_ready, out_mode, out_data);
    end
    sb.delete(); valid = 1'b0;
    #2 rst = 1'b0;
    repeat (2) tick(acc, got, seen);
    total++; if (out_valid !== 1'b0 || level !== 2'd0) begin
      bad++; $display("FAIL rst_no_partial valid %b level %0d want 0/0", out_valid, level);
    end
    ds_ready = 1'b1; valid = 1'b1; mode = 1'b0; data = {$urandom, $urandom, $urandom, $urandom};
    tick(acc, got, seen);
    valid = 1'b0;
    total++; if (acc !== 1'b1 || level !== 2'd1) begin
      bad++; $display("FAIL rst_push acc %b level %0d want 1/1", acc, level);
    end
    tick(acc, got, seen);
    total++;
    if (!got || sb.size() == 0) begin bad++; $display("FAIL rst_pop got %b want 1", got); end
    else begin
      e = sb.pop_front();
      if (seen !== e) begin bad++; $display("FAIL rst_data got %h want %h", seen, e); end
    end
  endtask

  initial begin
    test_reset();
    test_bits();
    test_round_trip();
    test_small();
    test_backpressure();
    test_streaming();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
